bound_flasher_param: RTL

Parametrised successor to the fixed 16-lamp bound-flasher datapath. It integrates the sequencing FSM, a thermometer level counter and a step prescaler.
- A single `flick` request starts a rise/fall lamp sequence across WIDTH lamps with three bound levels.
- A `flick` at kickback points during a rising phase sends the sequence back down.
- It sits between the push-button synchroniser and the lamp drivers.

---
 rtl/bound_flasher_param.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bound_flasher_param.sv
// bound_flasher_param: parametrised bound-flasher lamp sequencer with a
// rise/fall FSM, a thermometer level counter and a step prescaler.
// Ports: clk, rst (sync, active-high), flick (start/kickback request),
//        lamp[WIDTH] (registered drive), level (lit-lamp count),
//        busy (state != IDLE), done (one-cycle end-of-sequence pulse).
// Optional: define BOUND_FLASHER_BLINK_EN to add a BLINK tail after DN_C.
module bound_flasher_param #(
    parameter int WIDTH     = 16,
    parameter int STEP_DIV  = 1,
    parameter int LVL_A     = 6,
    parameter int LVL_B     = 11,
    parameter int LVL_LOW   = 5,
    parameter int KB_LO     = 5,
    parameter int KB_HI     = 10,
    parameter int BLINK_CNT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flick,
    output logic [WIDTH-1:0]             lamp,
    output logic [$clog2(WIDTH+1)-1:0]   level,
    output logic                         busy,
    output logic                         done
);
    localparam int LW = $clog2(WIDTH + 1);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [WIDTH-1:0] ALL1 = '1;

    if (!(WIDTH >= 4 && STEP_DIV >= 1 && BLINK_CNT >= 1 &&
          LVL_A > 0 && LVL_A <= WIDTH &&
          KB_LO > 0 && KB_LO < KB_HI && KB_HI < LVL_B && LVL_B <= WIDTH &&
          LVL_LOW < KB_HI)) begin : g_bad_params
        $error("bound_flasher_param: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP_A,
        S_DN_A,
        S_UP_B,
        S_DN_B,
        S_UP_C,
        S_DN_C
`ifdef BOUND_FLASHER_BLINK_EN
        , S_BLINK
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] lamp_q, lamp_d;
    logic             done_q, done_d;
    logic             tick;

`ifdef BOUND_FLASHER_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_CNT) + 1;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] blink_lamp;
`endif

    assign tick = (pre_q == PW'(STEP_DIV - 1));

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_d  = 1'b0;
        // Prescaler idles at zero, so entry from IDLE starts a full period.
        if (state_q == S_IDLE || tick) pre_d = '0;
        else                           pre_d = pre_q + PW'(1);
`ifdef BOUND_FLASHER_BLINK_EN
        bcnt_d     = bcnt_q;
        blink_lamp = lamp_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (flick) state_d = S_UP_A;
            end
            S_UP_A: if (tick) begin
                level_d = level_q + LW'(1);
                if (level_d == LW'(LVL_A)) state_d = S_DN_A;
            end
            S_DN_A: if (tick) begin
                level_d = level_q - LW'(1);
                if (level_d == '0) state_d = S_UP_B;
            end
            S_UP_B: if (tick) begin
                if (flick && (level_q == LW'(KB_LO) ||
                              level_q == LW'(KB_HI))) begin
                    level_d = level_q - LW'(1);
                    // A kickback from level 1 already sits at the DN_A floor.
                    state_d = (level_d == '0) ? S_UP_B : S_DN_A;
                end else begin
                    level_d = level_q + LW'(1);
                    if (level_d == LW'(LVL_B)) state_d = S_DN_B;
                end
            end
            S_DN_B: if (tick) begin
                level_d = level_q - LW'(1);
                if (level_d == LW'(LVL_LOW)) state_d = S_UP_C;
            end
            S_UP_C: if (tick) begin
                if (flick && level_q == LW'(KB_HI)) begin
                    level_d = level_q - LW'(1);
                    state_d = (level_d == LW'(LVL_LOW)) ? S_UP_C : S_DN_B;
                end else begin
                    level_d = level_q + LW'(1);
                    if (level_d == LW'(WIDTH)) state_d = S_DN_C;
                end
            end
            S_DN_C: if (tick) begin
                level_d = level_q - LW'(1);
                if (level_d == '0) begin
`ifdef BOUND_FLASHER_BLINK_EN
                    state_d = S_BLINK;
                    bcnt_d  = '0;
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef BOUND_FLASHER_BLINK_EN
            S_BLINK: if (tick) begin
                if (bcnt_q == BW'(2 * BLINK_CNT - 1)) begin
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                    bcnt_d     = '0;
                    blink_lamp = '0;
                end else begin
                    bcnt_d     = bcnt_q + BW'(1);
                    // Even ticks light everything, odd ticks blank.
                    blink_lamp = bcnt_q[0] ? '0 : ALL1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        lamp_d = ~(ALL1 << level_d);
`ifdef BOUND_FLASHER_BLINK_EN
        if (state_q == S_BLINK) lamp_d = blink_lamp;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            level_q <= '0;
            pre_q   <= '0;
            lamp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            pre_q   <= pre_d;
            lamp_q  <= lamp_d;
            done_q  <= done_d;
        end
    end

`ifdef BOUND_FLASHER_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) bcnt_q <= '0;
        else     bcnt_q <= bcnt_d;
    end
`endif

    assign lamp  = lamp_q;
    assign level = level_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;

    a_level_max: assert property (@(posedge clk) disable iff (rst)
        level_q <= LW'(WIDTH));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(tick && level_q == '0 &&
          (state_q == S_DN_A || state_q == S_DN_B || state_q == S_DN_C)));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(tick && level_q == LW'(WIDTH) &&
          (state_q == S_UP_A || state_q == S_UP_B || state_q == S_UP_C)));

endmodule
